blit_vid: RTL and testbench

//  Video back end directly downstream of the blit display DMA. Buffers the DMA

---
 rtl/blit_vid.sv | 173 +++++++++++++++++
 tb/tb_blit_vid.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/blit_vid.sv
// blit_vid: video back end for the blit display DMA -- word FIFO, raster timing, 1-bpp serializer.
// Optional feature macro: BLIT_VID_INVERT_EN (invert the shifted pixel during active video).
module blit_vid #(
    parameter int HACT   = 800,
    parameter int HFP    = 40,
    parameter int HSW    = 80,
    parameter int HBP    = 120,
    parameter int VACT   = 1024,
    parameter int VFP    = 3,
    parameter int VSW    = 7,
    parameter int VBP    = 29,
    parameter int CLKDIV = 1,
    parameter int FDEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixel_valid,
    input  logic [15:0] pixel_data,
    output logic        dmahstart,
    output logic        vblank,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic        vid_de,
    output logic        vid_pix,
    input  logic        err_clr,
    output logic        underrun,
    output logic        overflow
);
    localparam int HT = HACT + HFP + HSW + HBP;
    localparam int VT = VACT + VFP + VSW + VBP;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);
    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int AW = $clog2(FDEPTH);

`ifdef BLIT_VID_INVERT_EN
    localparam logic PIX_INV = 1'b1;
`else
    localparam logic PIX_INV = 1'b0;
`endif

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] hctr_q, hctr_d;
    logic [VW-1:0] vctr_q, vctr_d, vctr_nxt;
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, level;
    logic [15:0]   sh_q, sh_d, pop_word;
    logic [4:0]    cnt_q, cnt_d;
    logic          dmahstart_q, dmahstart_d, vblank_q, vblank_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, pix_q, pix_d;
    logic          underrun_q, underrun_d, overflow_q, overflow_d;
    logic          tick, line_end, active, flush, pop, wr_en, rd_en;
    logic          fifo_empty, fifo_full, pix_bit;
    logic [15:0]   fifo_mem [FDEPTH];

    always_comb begin
        tick     = (div_q == DW'(CLKDIV - 1));
        div_d    = tick ? '0 : div_q + 1'b1;
        line_end = (hctr_q == HW'(HT - 1));
        vctr_nxt = (vctr_q == VW'(VT - 1)) ? '0 : vctr_q + 1'b1;
        active   = (hctr_q < HW'(HACT)) && (vctr_q < VW'(VACT));
        hctr_d   = hctr_q;
        vctr_d   = vctr_q;
        if (tick) begin
            hctr_d = line_end ? '0 : hctr_q + 1'b1;
            if (line_end) begin
                vctr_d = vctr_nxt;
            end
        end
    end

    // Flush on entry to vblank discards any words the DMA left over from the last frame.
    always_comb begin
        level      = wptr_q - rptr_q;
        fifo_empty = (level == '0);
        fifo_full  = (level == (AW + 1)'(FDEPTH));
        flush      = tick && line_end && (vctr_q == VW'(VACT - 1));
        pop        = tick && active && ((hctr_q == '0) || (cnt_q == '0));
        wr_en      = pixel_valid && !fifo_full && !flush;
        rd_en      = pop && !fifo_empty;
        wptr_d     = wr_en ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = rd_en ? rptr_q + 1'b1 : rptr_q;
        if (flush) begin
            rptr_d = wptr_q;
        end
        pop_word   = rd_en ? fifo_mem[rptr_q[AW-1:0]] : '0;
    end

    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        pix_bit = 1'b0;
        if (pop) begin
            pix_bit = pop_word[15];
            sh_d    = {pop_word[14:0], 1'b0};
            cnt_d   = 5'd15;
        end else if (tick && active) begin
            pix_bit = sh_q[15];
            sh_d    = {sh_q[14:0], 1'b0};
            cnt_d   = cnt_q - 1'b1;
        end
    end

    // Outputs decode the position consumed by this tick, so they lag the counters by one tick.
    always_comb begin
        de_d     = de_q;
        pix_d    = pix_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        vblank_d = vblank_q;
        if (tick) begin
            de_d     = active;
            pix_d    = active && (pix_bit ^ PIX_INV);
            hsync_d  = (hctr_q >= HW'(HACT + HFP)) && (hctr_q < HW'(HACT + HFP + HSW));
            vsync_d  = (vctr_q >= VW'(VACT + VFP)) && (vctr_q < VW'(VACT + VFP + VSW));
            vblank_d = (vctr_q >= VW'(VACT));
        end
        dmahstart_d = tick && (hctr_q == HW'(HACT - 1)) && (vctr_nxt < VW'(VACT));
        underrun_d  = (pop && fifo_empty) ? 1'b1 : (err_clr ? 1'b0 : underrun_q);
        overflow_d  = (pixel_valid && fifo_full && !flush) ? 1'b1
                    : (err_clr ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wptr_q[AW-1:0]] <= pixel_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            hctr_q      <= '0;
            vctr_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
            dmahstart_q <= 1'b0;
            vblank_q    <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
            pix_q       <= 1'b0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            hctr_q      <= hctr_d;
            vctr_q      <= vctr_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            dmahstart_q <= dmahstart_d;
            vblank_q    <= vblank_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            pix_q       <= pix_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
        end
    end

    assign dmahstart = dmahstart_q;
    assign vblank    = vblank_q;
    assign vid_hsync = hsync_q;
    assign vid_vsync = vsync_q;
    assign vid_de    = de_q;
    assign vid_pix   = pix_q;
    assign underrun  = underrun_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_blit_vid.sv
// Directed bench for blit_vid with a tiny raster (40 px x 7 lines, 2 clks per pixel).
// Cycle numbers count posedges since reset release; pixel (h,v) of frame f shows after edge 2+2*(h+40*v+280*f).
module tb_blit_vid;
    logic        clk = 1'b0;
    logic        rst;
    logic        pixel_valid;
    logic [15:0] pixel_data;
    logic        err_clr;
    logic        dmahstart, vblank, vid_hsync, vid_vsync, vid_de, vid_pix, underrun, overflow;

    int cyc;
    int n_cmp = 0;
    int n_bad = 0;
    int cnt_hs = 0, cnt_vs = 0, cnt_dma = 0, cnt_vb = 0, cnt_de = 0;
    logic [31:0] line_pix;

    blit_vid #(
        .HACT(32), .HFP(2), .HSW(3), .HBP(3),
        .VACT(4), .VFP(1), .VSW(1), .VBP(1),
        .CLKDIV(2), .FDEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .dmahstart(dmahstart), .vblank(vblank), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
        .vid_de(vid_de), .vid_pix(vid_pix), .err_clr(err_clr),
        .underrun(underrun), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] all_outs();
        return {dmahstart, vblank, vid_hsync, vid_vsync, vid_de, vid_pix, underrun, overflow};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (cyc >= 2 && cyc <= 561) begin
            cnt_hs  += int'(vid_hsync);
            cnt_vs  += int'(vid_vsync);
            cnt_dma += int'(dmahstart);
            cnt_vb  += int'(vblank);
            cnt_de  += int'(vid_de);
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic write_word(input logic [15:0] w);
        pixel_valid = 1'b1;
        pixel_data  = w;
        step();
        pixel_valid = 1'b0;
        pixel_data  = 16'h0;
    endtask

    task automatic grab_line(input int base, output logic [31:0] v);
        v = '0;
        for (int h = 0; h < 32; h++) begin
            run_to(base + 2 * h);
            v[31 - h] = vid_pix;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pixel_valid = 1'b0;
        pixel_data = 16'h0;
        err_clr = 1'b0;
        cyc = 0;
        repeat (3) @(negedge clk);
        check_val("reset_outs", 32'(all_outs()), 32'h0);
        rst = 1'b0;
        cyc = 0;

        // Free run from reset; line 0 has no data so it underruns at its first pixel.
        step();
        check_val("post_rst_outs", 32'(all_outs()), 32'h0);
        run_to(2);
        check_val("first_de", 32'(vid_de), 32'd1);
        check_val("first_pix", 32'(vid_pix), 32'd0);
        check_val("first_underrun", 32'(underrun), 32'd1);
        run_to(63);  check_val("dma_before", 32'(dmahstart), 32'd0);
        run_to(64);  check_val("dma_h32_l0", 32'(dmahstart), 32'd1);
        run_to(65);  check_val("dma_after", 32'(dmahstart), 32'd0);
        run_to(66);  check_val("de_h32", 32'(vid_de), 32'd0);
        run_to(69);  check_val("hs_pre", 32'(vid_hsync), 32'd0);
        run_to(70);  check_val("hs_rise", 32'(vid_hsync), 32'd1);
        run_to(75);  check_val("hs_last", 32'(vid_hsync), 32'd1);
        run_to(76);  check_val("hs_fall", 32'(vid_hsync), 32'd0);

        run_to(400);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_val("underrun_clr", 32'(underrun), 32'd0);

        // Two words per fetch for frame 1 line 0.
        run_to(544);
        check_val("dma_l6", 32'(dmahstart), 32'd1);
        write_word(16'hA5A5);
        write_word(16'hFFFF);
        run_to(561);
        check_val("frame_hsync_clks", 32'(cnt_hs), 32'd42);
        check_val("frame_vsync_clks", 32'(cnt_vs), 32'd80);
        check_val("frame_dma_pulses", 32'(cnt_dma), 32'd4);
        check_val("frame_vblank_clks", 32'(cnt_vb), 32'd240);
        check_val("frame_de_clks", 32'(cnt_de), 32'd256);
        grab_line(562, line_pix);
        check_val("line_a5a5_ffff", line_pix, 32'hA5A5FFFF);
        check_val("no_underrun_1", 32'(underrun), 32'd0);
        check_val("no_overflow_1", 32'(overflow), 32'd0);

        // Five words into a four-deep FIFO: the fifth is dropped.
        run_to(624);
        check_val("dma_f1_l0", 32'(dmahstart), 32'd1);
        write_word(16'h1111);
        write_word(16'h2222);
        write_word(16'h3333);
        write_word(16'h4444);
        check_val("ovf_at_full", 32'(overflow), 32'd0);
        write_word(16'h5555);
        check_val("ovf_set", 32'(overflow), 32'd1);
        grab_line(642, line_pix);
        check_val("line_1111_2222", line_pix, 32'h11112222);
        grab_line(722, line_pix);
        check_val("line_3333_4444", line_pix, 32'h33334444);
        check_val("no_underrun_2", 32'(underrun), 32'd0);

        // Three words for the last active line; the leftover must be flushed at vblank.
        run_to(784);
        check_val("dma_f1_l2", 32'(dmahstart), 32'd1);
        write_word(16'h00FF);
        write_word(16'hF0F0);
        write_word(16'h1234);
        grab_line(802, line_pix);
        check_val("line_00ff_f0f0", line_pix, 32'h00FFF0F0);
        run_to(881); check_val("vblank_pre", 32'(vblank), 32'd0);
        run_to(882); check_val("vblank_rise", 32'(vblank), 32'd1);
        run_to(999);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_val("ovf_clr", 32'(overflow), 32'd0);
        run_to(1104);
        check_val("dma_f1_l6", 32'(dmahstart), 32'd1);
        write_word(16'hC3C3);
        write_word(16'h0F0F);
        grab_line(1122, line_pix);
        check_val("line_after_flush", line_pix, 32'hC3C30F0F);
        check_val("no_underrun_3", 32'(underrun), 32'd0);

        // Reset in the middle of an underrunning active line.
        run_to(1210);
        check_val("pre_rst_de", 32'(vid_de), 32'd1);
        check_val("pre_rst_underrun", 32'(underrun), 32'd1);
        #2 rst = 1'b1;
        #1 check_val("midline_rst_outs", 32'(all_outs()), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        run_to(1);  check_val("rst2_idle", 32'(all_outs()), 32'h0);
        run_to(2);  check_val("rst2_de", 32'(vid_de), 32'd1);
        run_to(63); check_val("rst2_dma_pre", 32'(dmahstart), 32'd0);
        run_to(64); check_val("rst2_dma_h32", 32'(dmahstart), 32'd1);
        run_to(65); check_val("rst2_dma_post", 32'(dmahstart), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
